field_merge_scheduler: RTL and testbench
========================================

# field_merge_scheduler

Output-side scheduler for the protobuf serializer. It sits between the two encoded-byte streams (varint out FIFO and raw-data out FIFO) and the shared output FIFO that feeds the AXI read channel. It grants the output FIFO to one source at a time, always picking the pending field with the lowest field index. It then streams that field's bytes whole, so fields never interleave in the serialized message.

## Interface
Parameters:
- INDEX_W, 10, field-index width (matches index FIFOs)
- DATA_W, 8, encoded byte width
- CNT_W, 16, field counter width

Ports:
- clock_clk  in  1  sole clock
- reset_reset_n  in  1  asynchronous, active-low reset
- varint_valid  in  1  varint out FIFO non-empty (show-ahead)
- varint_data  in  DATA_W  head byte of varint stream
- varint_index  in  INDEX_W  field index of head byte
- varint_last  in  1  head byte is final byte of its field
- varint_pop  out  1  consume head varint byte
- raw_valid  in  1  raw-data out FIFO non-empty (show-ahead)
- raw_data  in  DATA_W  head byte of raw stream
- raw_index  in  INDEX_W  field index of head byte
- raw_last  in  1  head byte is final byte of its field
- raw_pop  out  1  consume head raw byte
- out_fifo_full  in  1  output FIFO full
- out_fifo_push  out  1  write strobe to output FIFO
- out_fifo_data  out  DATA_W  byte to output FIFO
- flush  in  1  synchronous clear (message abort)
- busy  out  1  a field grant is active
- field_count  out  CNT_W  fields completed since reset/flush
- index_err  out  1  sticky: index changed inside a granted field

## Operation
- Reset is asynchronous and active-low: clock_clk is the only clock, and reset_reset_n is asynchronous and active-low. The polarity and synchronicity are fixed.
- States: IDLE, ARB, GRANT_V, GRANT_R.
- IDLE: if varint_valid or raw_valid, go to ARB. Otherwise stay.
- ARB: one decision cycle.
  - Both valid: the lower index wins. A tie goes to varint.
  - One valid: that source wins.
  - Neither valid: return to IDLE.
  - Latch the winner's index into cur_index and go to GRANT_V or GRANT_R.
- GRANT_x transfer rule: transfer = x_valid & ~out_fifo_full.
  - x_pop = out_fifo_push = transfer, combinational.
  - out_fifo_data = x_data, muxed by grant. It is 0 when not granted.
- GRANT_x index check: if a transferred byte has x_index != cur_index, set index_err. The byte is still transferred.
- GRANT_x field end: a transfer with x_last=1 increments field_count and moves to IDLE.
- The non-granted pop is always 0. Never pop both sources in one cycle.
- busy = 1 in GRANT_V and GRANT_R only.
- flush has priority over everything except reset.
  - On the next edge: state goes to IDLE, and field_count and index_err go to 0.
  - In the flush cycle: pops and push are forced to 0.
- field_count wraps modulo 2^CNT_W.

## Timing
- Reset values: state=IDLE, varint_pop=0, raw_pop=0, out_fifo_push=0, out_fifo_data=0, busy=0, field_count=0, index_err=0, cur_index=0.
- Reset assertion mid-field: immediate asynchronous return to IDLE. The partial field is abandoned and no further pops occur.
- Arbitration latency: first push occurs 2 cycles after a source's valid rises with the FSM in IDLE (IDLE→ARB→GRANT).
- Steady state: 1 byte/cycle while valid and not full.
- Per-field overhead: 2 bubble cycles after the last byte (GRANT→IDLE→ARB).
- Grant hold: the grant persists across valid gaps and full stalls until the last byte is transferred. No timeout and no preemption, even if the other source presents a lower index.
- out_fifo_full and valid are sampled in the same cycle as the pop. No byte is lost or duplicated at the full boundary.
- A valid that drops in ARB after the decision still enters GRANT. The grant then waits.

## Test plan
- Single varint field: varint bytes 0x96,0x01 at index 3, last on 0x01; raw idle → push 0x96 then 0x01 on consecutive cycles starting 2 cycles after valid. field_count=1, then IDLE.
- Ordering: varint index 5 (1 byte 0x08) and raw index 2 (3 bytes 0x41,0x42,0x43) both valid at once → output 0x41,0x42,0x43,0x08. field_count=2. varint_pop never asserted during the raw grant.
- Tie and no-preempt: both at index 7 → varint field emitted first. Then present raw index 1 mid-field → varint field still completes before raw.
- Backpressure: assert out_fifo_full for 4 cycles mid-field → no pops or pushes while full. Exact byte sequence preserved. Resume on the cycle full drops.
- Index error and flush: raw field index 4 whose second byte carries index 6 → index_err=1 after that transfer. Pulse flush → index_err=0, field_count=0, IDLE, no push in the flush cycle.
- Async reset mid-field: drop reset_reset_n between clock edges during a 4-byte grant → all outputs 0 immediately. After release, the FSM re-arbitrates from IDLE.

Source files
------------

// File: rtl/field_merge_scheduler.sv
// Output-side field scheduler: grants the output FIFO to the varint or raw
// stream one whole field at a time, always choosing the lowest field index.
module field_merge_scheduler #(
  parameter int INDEX_W = 10,
  parameter int DATA_W  = 8,
  parameter int CNT_W   = 16
) (
  input  logic               clock_clk,
  input  logic               reset_reset_n,
  input  logic               varint_valid,
  input  logic [DATA_W-1:0]  varint_data,
  input  logic [INDEX_W-1:0] varint_index,
  input  logic               varint_last,
  output logic               varint_pop,
  input  logic               raw_valid,
  input  logic [DATA_W-1:0]  raw_data,
  input  logic [INDEX_W-1:0] raw_index,
  input  logic               raw_last,
  output logic               raw_pop,
  input  logic               out_fifo_full,
  output logic               out_fifo_push,
  output logic [DATA_W-1:0]  out_fifo_data,
  input  logic               flush,
  output logic               busy,
  output logic [CNT_W-1:0]   field_count,
  output logic               index_err
);

  typedef enum logic [1:0] {
    IDLE,
    ARB,
    GRANT_V,
    GRANT_R
  } state_t;

  state_t             state_q, state_d;
  logic [INDEX_W-1:0] cur_index_q, cur_index_d;
  logic [CNT_W-1:0]   field_count_q;
  logic               index_err_q;
  logic               v_win;
  logic               v_xfer, r_xfer;
  logic               field_done;
  logic               xfer_bad;

  // Ties on index go to the varint stream.
  assign v_win = varint_valid &
                 (~raw_valid | (varint_index <= raw_index));

  always_comb begin
    state_d     = state_q;
    cur_index_d = cur_index_q;
    v_xfer      = 1'b0;
    r_xfer      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (varint_valid | raw_valid)
          state_d = ARB;
      end
      ARB: begin
        if (v_win) begin
          state_d     = GRANT_V;
          cur_index_d = varint_index;
        end else if (raw_valid) begin
          state_d     = GRANT_R;
          cur_index_d = raw_index;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT_V: begin
        v_xfer = varint_valid & ~out_fifo_full & ~flush;
        if (v_xfer & varint_last)
          state_d = IDLE;
      end
      GRANT_R: begin
        r_xfer = raw_valid & ~out_fifo_full & ~flush;
        if (r_xfer & raw_last)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush)
      state_d = IDLE;
  end

  assign field_done = (v_xfer & varint_last) |
                      (r_xfer & raw_last);
  assign xfer_bad   = (v_xfer & (varint_index != cur_index_q)) |
                      (r_xfer & (raw_index != cur_index_q));

  always_ff @(posedge clock_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q       <= IDLE;
      cur_index_q   <= '0;
      field_count_q <= '0;
      index_err_q   <= 1'b0;
    end else if (flush) begin
      state_q       <= IDLE;
      field_count_q <= '0;
      index_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_index_q <= cur_index_d;
      if (field_done)
        field_count_q <= field_count_q + 1'b1;
      if (xfer_bad)
        index_err_q <= 1'b1;
    end
  end

  always_comb begin
    out_fifo_data = '0;
    unique case (1'b1)
      (state_q == GRANT_V): out_fifo_data = varint_data;
      (state_q == GRANT_R): out_fifo_data = raw_data;
      default:              out_fifo_data = '0;
    endcase
  end

  assign varint_pop    = v_xfer;
  assign raw_pop       = r_xfer;
  assign out_fifo_push = v_xfer | r_xfer;
  assign busy          = (state_q == GRANT_V) |
                         (state_q == GRANT_R);
  assign field_count   = field_count_q;
  assign index_err     = index_err_q;

endmodule

// File: tb/tb_field_merge_scheduler.sv
// Bench for field_merge_scheduler: queue-modelled show-ahead sources,
// expected-byte scoreboard, arbitration vector table, hand-written corners.
module tb_field_merge_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        varint_valid, raw_valid;
  logic [7:0]  varint_data, raw_data;
  logic [9:0]  varint_index, raw_index;
  logic        varint_last, raw_last;
  logic        varint_pop, raw_pop;
  logic        out_fifo_full, out_fifo_push;
  logic [7:0]  out_fifo_data;
  logic        flush, busy, index_err;
  logic [15:0] field_count;

  field_merge_scheduler dut (
    .clock_clk     (clk),
    .reset_reset_n (rst_n),
    .varint_valid  (varint_valid),
    .varint_data   (varint_data),
    .varint_index  (varint_index),
    .varint_last   (varint_last),
    .varint_pop    (varint_pop),
    .raw_valid     (raw_valid),
    .raw_data      (raw_data),
    .raw_index     (raw_index),
    .raw_last      (raw_last),
    .raw_pop       (raw_pop),
    .out_fifo_full (out_fifo_full),
    .out_fifo_push (out_fifo_push),
    .out_fifo_data (out_fifo_data),
    .flush         (flush),
    .busy          (busy),
    .field_count   (field_count),
    .index_err     (index_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic [9:0] i;
    logic       l;
  } sb_t;

  typedef struct {
    logic       vv;
    logic [9:0] vi;
    logic [7:0] vd;
    logic       rv;
    logic [9:0] ri;
    logic [7:0] rd;
    logic [7:0] e0;
    logic [7:0] e1;
    int         nf;
  } vec_t;

  sb_t        vq[$];
  sb_t        rq[$];
  logic [7:0] exp_q[$];
  int         push_cyc[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         exp_fc = 0;
  logic       last_vpop = 1'b0;
  logic       last_rpop = 1'b0;
  logic       full_ctl = 1'b0;
  logic       flush_ctl = 1'b0;
  logic [7:0] last_push_data = 8'h00;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic drive();
    varint_valid = (vq.size() > 0);
    varint_data  = varint_valid ? vq[0].d : 8'h00;
    varint_index = varint_valid ? vq[0].i : 10'd0;
    varint_last  = varint_valid ? vq[0].l : 1'b0;
    raw_valid    = (rq.size() > 0);
    raw_data     = raw_valid ? rq[0].d : 8'h00;
    raw_index    = raw_valid ? rq[0].i : 10'd0;
    raw_last     = raw_valid ? rq[0].l : 1'b0;
    out_fifo_full = full_ctl;
    flush         = flush_ctl;
  endtask

  task automatic monitor();
    logic [7:0] e;
    if (out_fifo_push | varint_pop | raw_pop) begin
      chk("one_pop", 32'(varint_pop & raw_pop), 0);
      chk("pop_eq_push", 32'(varint_pop | raw_pop), 32'(out_fifo_push));
      chk("push_while_full", 32'(out_fifo_full), 0);
      chk("push_in_flush", 32'(flush), 0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_push: got %0h expected none (cyc %0d)",
                 out_fifo_data, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", 32'(out_fifo_data), 32'(e));
      end
      push_cyc.push_back(cyc);
      last_push_data = out_fifo_data;
    end
    last_vpop = varint_pop;
    last_rpop = raw_pop;
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled on the
  // falling edge, which shows what the DUT will commit at the next edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (last_vpop && vq.size() > 0) vq.delete(0);
    if (last_rpop && rq.size() > 0) rq.delete(0);
    cyc++;
    drive();
    @(negedge clk);
    monitor();
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((vq.size() || rq.size() || exp_q.size()) && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d bytes left expected 0",
               nm, exp_q.size());
      vq.delete();
      rq.delete();
      exp_q.delete();
    end
    step();
  endtask

  task automatic wait_pushes(input int target);
    int n = 0;
    while (push_cyc.size() < target && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL push_wait: got %0d pushes expected %0d",
               push_cyc.size(), target);
    end
  endtask

  vec_t tbl[6];

  initial begin
    int start;
    tbl[0] = '{1'b1, 10'd5, 8'h08, 1'b1, 10'd2, 8'h41, 8'h41, 8'h08, 2};
    tbl[1] = '{1'b1, 10'd3, 8'h11, 1'b1, 10'd9, 8'h22, 8'h11, 8'h22, 2};
    tbl[2] = '{1'b1, 10'd7, 8'h33, 1'b1, 10'd7, 8'h44, 8'h33, 8'h44, 2};
    tbl[3] = '{1'b1, 10'd0, 8'h55, 1'b0, 10'd0, 8'h00, 8'h55, 8'h00, 1};
    tbl[4] = '{1'b0, 10'd0, 8'h00, 1'b1, 10'd1023, 8'h66, 8'h66, 8'h00, 1};
    tbl[5] = '{1'b1, 10'd1023, 8'h77, 1'b1, 10'd0, 8'h88, 8'h88, 8'h77, 2};

    rst_n = 1'b0;
    drive();
    #1;
    chk("rst_push", 32'(out_fifo_push), 0);
    chk("rst_vpop", 32'(varint_pop), 0);
    chk("rst_rpop", 32'(raw_pop), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_data", 32'(out_fifo_data), 0);
    chk("rst_fc", 32'(field_count), 0);
    chk("rst_ierr", 32'(index_err), 0);
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // single two-byte varint field, first push two cycles after valid
    push_cyc.delete();
    start = cyc + 1;
    vq.push_back('{8'h96, 10'd3, 1'b0});
    vq.push_back('{8'h01, 10'd3, 1'b1});
    exp_q.push_back(8'h96);
    exp_q.push_back(8'h01);
    drain("single");
    exp_fc++;
    chk("single_npush", push_cyc.size(), 2);
    if (push_cyc.size() == 2) begin
      chk("single_lat0", push_cyc[0], start + 2);
      chk("single_lat1", push_cyc[1], start + 3);
    end
    chk("single_fc", 32'(field_count), exp_fc);
    chk("single_idle", 32'(busy), 0);

    // raw index 2 beats varint index 5
    rq.push_back('{8'h41, 10'd2, 1'b0});
    rq.push_back('{8'h42, 10'd2, 1'b0});
    rq.push_back('{8'h43, 10'd2, 1'b1});
    vq.push_back('{8'h08, 10'd5, 1'b1});
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h42);
    exp_q.push_back(8'h43);
    exp_q.push_back(8'h08);
    drain("order");
    exp_fc += 2;
    chk("order_fc", 32'(field_count), exp_fc);

    for (int k = 0; k < 6; k++) begin
      if (tbl[k].vv) vq.push_back('{tbl[k].vd, tbl[k].vi, 1'b1});
      if (tbl[k].rv) rq.push_back('{tbl[k].rd, tbl[k].ri, 1'b1});
      exp_q.push_back(tbl[k].e0);
      if (tbl[k].nf == 2) exp_q.push_back(tbl[k].e1);
      drain("table");
      exp_fc += tbl[k].nf;
      chk("table_fc", 32'(field_count), exp_fc);
    end

    // a lower raw index arriving mid-field must not preempt
    push_cyc.delete();
    vq.push_back('{8'hA1, 10'd7, 1'b0});
    vq.push_back('{8'hA2, 10'd7, 1'b0});
    vq.push_back('{8'hA3, 10'd7, 1'b1});
    exp_q.push_back(8'hA1);
    exp_q.push_back(8'hA2);
    exp_q.push_back(8'hA3);
    wait_pushes(1);
    rq.push_back('{8'hEE, 10'd1, 1'b1});
    exp_q.push_back(8'hEE);
    drain("preempt");
    exp_fc += 2;
    chk("preempt_fc", 32'(field_count), exp_fc);

    // four full cycles mid-field
    push_cyc.delete();
    for (int b = 0; b < 5; b++) begin
      vq.push_back('{8'hB0 + 8'(b), 10'd11, (b == 4)});
      exp_q.push_back(8'hB0 + 8'(b));
    end
    wait_pushes(2);
    full_ctl = 1'b1;
    repeat (4) step();
    chk("stall_npush", push_cyc.size(), 2);
    full_ctl = 1'b0;
    step();
    chk("resume_push", 32'(out_fifo_push), 1);
    drain("bp");
    exp_fc++;
    chk("bp_fc", 32'(field_count), exp_fc);

    // index changes inside a granted raw field
    chk("ierr_pre", 32'(index_err), 0);
    rq.push_back('{8'h10, 10'd4, 1'b0});
    rq.push_back('{8'h11, 10'd6, 1'b1});
    exp_q.push_back(8'h10);
    exp_q.push_back(8'h11);
    drain("ierr");
    exp_fc++;
    chk("ierr_set", 32'(index_err), 1);
    chk("ierr_fc", 32'(field_count), exp_fc);

    // flush in the first granted cycle
    rq.push_back('{8'h55, 10'd2, 1'b1});
    exp_q.push_back(8'h55);
    step();
    step();
    flush_ctl = 1'b1;
    step();
    chk("flush_busy_before", 32'(busy), 1);
    chk("flush_push", 32'(out_fifo_push), 0);
    chk("flush_pop", 32'(raw_pop), 0);
    flush_ctl = 1'b0;
    step();
    exp_fc = 0;
    chk("flush_fc", 32'(field_count), exp_fc);
    chk("flush_ierr", 32'(index_err), 0);
    chk("flush_idle", 32'(busy), 0);
    drain("post_flush");
    exp_fc++;
    chk("post_flush_fc", 32'(field_count), exp_fc);

    // asynchronous reset between edges during a four-byte grant
    push_cyc.delete();
    for (int b = 0; b < 4; b++) begin
      vq.push_back('{8'hC0 + 8'(b), 10'd9, (b == 3)});
      exp_q.push_back(8'hC0 + 8'(b));
    end
    wait_pushes(2);
    // the byte just seen was never committed: no edge reached it
    #2 rst_n = 1'b0;
    #1;
    exp_q.push_front(last_push_data);
    last_vpop = 1'b0;
    last_rpop = 1'b0;
    chk("arst_push", 32'(out_fifo_push), 0);
    chk("arst_vpop", 32'(varint_pop), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_data", 32'(out_fifo_data), 0);
    chk("arst_fc", 32'(field_count), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    drain("arst");
    chk("arst_fc_after", 32'(field_count), 1);
    chk("arst_idle", 32'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
